aes_pipe_ctrl: RTL and testbench
================================

Name: aes_pipe_ctrl

Overview:
Parametrised control and result-buffering block for the pipelined AES encryption datapath. It replaces the fixed 11-stage enable shift with an NR-generic valid/tag pipeline, adds valid/ready handshakes at input and output, and uses credit-based admission so the non-stallable round pipeline never overflows. It also sequences round-key reloads safely by draining in-flight blocks first. It sits between the host interface and the round instances; the round datapath itself stays outside.

Parameters:
NR, 10, number of cipher rounds (10 = AES-128, 14 = AES-256); there are NR+1 stages (round 0 to round NR).
BLOCK_LENGTH, 128, result data width.
TAG_W, 4, width of the user tag carried alongside each block.
OUT_DEPTH, 4, result FIFO depth; power of 2, at least 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
in_valid  in  1  host offers a plaintext block
in_ready  out  1  block accepted when in_valid & in_ready
in_tag  in  TAG_W  tag for the offered block
stage_en  out  NR+1  per-round enable; bit i enables round i
res_data  in  BLOCK_LENGTH  registered output of the last round
key_valid  in  1  host requests a new key load
key_ready  out  1  new key accepted when key_valid & key_ready
key_start  out  1  one-cycle pulse that starts key expansion and latches KEY
key_done  in  1  key expansion complete (level or pulse)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pops when out_valid & out_ready
out_data  out  BLOCK_LENGTH  FIFO head ciphertext
out_tag  out  TAG_W  FIFO head tag

Behaviour:
- One clock. Reset is synchronous and active-low: the block resets only on a clk edge where rst==0.
- Reset values:
  - All registered state is cleared.
  - stage_en=0, in_ready=0, key_ready=0, key_start=0, out_valid=0, out_data=0, out_tag=0.
  - FIFO is empty, inflight=0, state=IDLE.
- Reset mid-operation discards all in-flight blocks and all FIFO contents.
- Valid pipeline:
  - v[0] <= accept; v[i] <= v[i-1]; stage_en = v.
  - Tags shift in parallel with v.
  - A one-cycle delayed copy of v[NR] (wr_en) writes {res_data, tag} into the FIFO.
- Latency: with the FIFO empty, out_valid rises NR+3 cycles after the accepting cycle (13 for NR=10). Back-to-back accepts give one result per cycle.
- Credits:
  - inflight (width clog2(OUT_DEPTH+1)) increments on accept and decrements on wr_en.
  - in_ready = (state==RUN) & ~key_valid & (inflight + fifo_count < OUT_DEPTH).
  - in_ready is computed from registered values only; a pop frees its credit on the following cycle.
- FIFO:
  - Simultaneous write and pop is allowed, and the count is unchanged.
  - A write can never occur when the FIFO is full; this is guaranteed by the credit rule.
  - out_data and out_tag hold their value while out_valid & ~out_ready.
- FSM states: IDLE, EXPAND, RUN, DRAIN.
  - IDLE: key_ready=1. On key_valid go to EXPAND, with key_start high for exactly the first EXPAND cycle.
  - EXPAND: in_ready=0. On key_done go to RUN. A key_done arriving in the key_start cycle is honoured.
  - RUN: on key_valid go to DRAIN. in_ready is low that same cycle.
  - DRAIN: in_ready=0. key_ready = (inflight==0). On handshake go to EXPAND.
- The FIFO continues to drain through all states; key reload does not wait for the FIFO.
- key_valid deasserted in DRAIN before the handshake returns the FSM to RUN.

Optional Feature:
AES_PIPE_PERF_EN
- Defined: adds outputs perf_blocks (32-bit count of FIFO pops) and perf_stalls (32-bit count of cycles with in_valid & ~in_ready). Both wrap at 2^32, clear on reset, and are readable at any time.
- Undefined: neither the ports nor the counters exist.

Decomposition:
- Package aes_pipe_pkg holds:
  - the FSM state enum (2-bit);
  - the NR_AES128=10 and NR_AES256=14 constants;
  - a clog2-based width helper for inflight and FIFO pointers.
- One sub-module: aes_res_fifo, a synchronous FIFO of width BLOCK_LENGTH+TAG_W and depth OUT_DEPTH with count output.

Test Plan:
- Reset, then key_valid=1 and key_done 5 cycles after key_start → key_start high exactly 1 cycle, then RUN with in_ready=1.
- NR=10, single accept with tag 0x3 and res_data driven 0xA5..A5 → stage_en walks bits 0..10 one per cycle; out_valid rises 13 cycles after accept with out_tag=3 and out_data=0xA5..A5.
- NR=14, out_ready=0, continuous in_valid → exactly OUT_DEPTH=4 accepts, then in_ready=0. After 4 pops, exactly 4 more accepts occur; no FIFO overflow and tag order is preserved.
- key_valid asserted with 3 blocks in flight → in_ready drops that cycle; key_ready rises only once inflight=0; all 3 results are still delivered, then EXPAND.
- rst=0 for one edge mid-stream with 5 blocks in flight → the next cycle has stage_en=0, out_valid=0, state IDLE; no stale result appears afterwards.
- With AES_PIPE_PERF_EN defined, 10 pops and 7 stalled cycles → perf_blocks=10, perf_stalls=7.

Source files
------------

// File: rtl/aes_pipe_pkg.sv
// Shared types and helpers for the AES pipeline controller.
// Holds the controller FSM encoding, the standard AES round counts and
// width helpers used for the credit counter and FIFO pointers.
package aes_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } pipe_state_t;

  localparam int NR_AES128 = 10;
  localparam int NR_AES256 = 14;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n entries (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_res_fifo.sv
// Result FIFO for the AES pipeline: show-ahead synchronous FIFO with an
// occupancy count. The head is forced to zero while empty so the
// outputs read zero after reset. Writes are never issued when full
// because the controller admits blocks against FIFO credits.
module aes_res_fifo
  import aes_pipe_pkg::*;
#(
  parameter int WIDTH = 132,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          not_empty,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_rd;

  assign do_rd     = rd_en & (count_reg != '0);
  assign not_empty = (count_reg != '0);
  assign count     = count_reg;
  assign rd_data   = not_empty ? mem[rd_ptr_reg] : '0;

  // Storage write; contents need no clearing because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers and occupancy; a simultaneous write and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({wr_en, do_rd})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/aes_pipe_ctrl.sv
// Control and result buffering for the pipelined AES datapath.
// Carries a valid/tag token through NR+1 round stages, admits blocks only
// while FIFO credits remain, and drains in-flight blocks before a key reload.
// Optional macro AES_PIPE_PERF_EN adds perf_blocks / perf_stalls counters.
module aes_pipe_ctrl
  import aes_pipe_pkg::*;
#(
  parameter int NR           = NR_AES128,
  parameter int BLOCK_LENGTH = 128,
  parameter int TAG_W        = 4,
  parameter int OUT_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [NR:0]             stage_en,
  input  logic [BLOCK_LENGTH-1:0] res_data,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic                    key_start,
  input  logic                    key_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out_data,
`ifdef AES_PIPE_PERF_EN
  output logic [31:0]             perf_blocks,
  output logic [31:0]             perf_stalls,
`endif
  output logic [TAG_W-1:0]        out_tag
);

  localparam int CW = cnt_width(OUT_DEPTH);
  localparam int FW = BLOCK_LENGTH + TAG_W;

  pipe_state_t               state_reg, state_next;
  logic                      key_start_reg, key_start_next;
  logic [NR:0]               v_reg;
  logic [NR:0][TAG_W-1:0]    tag_reg;
  logic                      wr_en_reg;
  logic [TAG_W-1:0]          wr_tag_reg;
  logic [CW-1:0]             inflight_reg;
  logic [CW-1:0]             fifo_count;
  logic [CW:0]               credits_used;
  logic                      accept;
  logic [FW-1:0]             head;

  // Admission uses only registered occupancy, so a pop frees its credit a cycle later.
  assign credits_used = {1'b0, inflight_reg} + {1'b0, fifo_count};
  assign in_ready  = rst & (state_reg == RUN) & ~key_valid &
                     (credits_used < (CW+1)'(OUT_DEPTH));
  assign key_ready = rst & ((state_reg == IDLE) |
                            ((state_reg == DRAIN) & (inflight_reg == '0)));
  assign key_start = key_start_reg;
  assign accept    = in_valid & in_ready;
  assign stage_en  = v_reg;

  // FSM state register plus the registered key_start pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      key_start_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_start_reg <= key_start_next;
    end
  end

  // Next-state logic; key_start fires on every entry into EXPAND.
  always_comb begin
    state_next     = state_reg;
    key_start_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_valid) begin
          state_next     = EXPAND;
          key_start_next = 1'b1;
        end
      end
      EXPAND: begin
        if (key_done) state_next = RUN;
      end
      RUN: begin
        if (key_valid) state_next = DRAIN;
      end
      DRAIN: begin
        if (!key_valid) begin
          state_next = RUN;
        end else if (inflight_reg == '0) begin
          state_next     = EXPAND;
          key_start_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Valid/tag token pipeline; the extra stage lines the tag up with res_data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_reg      <= '0;
      tag_reg    <= '0;
      wr_en_reg  <= 1'b0;
      wr_tag_reg <= '0;
    end else begin
      v_reg      <= {v_reg[NR-1:0], accept};
      tag_reg    <= {tag_reg[NR-1:0], in_tag};
      wr_en_reg  <= v_reg[NR];
      wr_tag_reg <= tag_reg[NR];
    end
  end

  // Blocks in the round pipeline; each leaves the count as it enters the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_reg <= '0;
    end else begin
      case ({accept, wr_en_reg})
        2'b10:   inflight_reg <= inflight_reg + CW'(1);
        2'b01:   inflight_reg <= inflight_reg - CW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  aes_res_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en_reg),
    .wr_data   ({res_data, wr_tag_reg}),
    .rd_en     (out_ready),
    .rd_data   (head),
    .not_empty (out_valid),
    .count     (fifo_count)
  );

  assign out_data = head[FW-1:TAG_W];
  assign out_tag  = head[TAG_W-1:0];

`ifdef AES_PIPE_PERF_EN
  logic [31:0] perf_blocks_reg;
  logic [31:0] perf_stalls_reg;

  // Free-running pop and stall counters that wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_blocks_reg <= '0;
      perf_stalls_reg <= '0;
    end else begin
      if (out_valid & out_ready) perf_blocks_reg <= perf_blocks_reg + 32'd1;
      if (in_valid & ~in_ready)  perf_stalls_reg <= perf_stalls_reg + 32'd1;
    end
  end

  assign perf_blocks = perf_blocks_reg;
  assign perf_stalls = perf_stalls_reg;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Self-checking bench for aes_pipe_ctrl (NR=10, OUT_DEPTH=4).
// A shift register stands in for the round datapath so that res_data
// carries the data of the block that was accepted NR+1 edges earlier.
// Perf counter checks are built when AES_PIPE_PERF_EN is defined.
module tb_aes_pipe_ctrl;

  localparam int NR = 10;
  localparam int BL = 128;
  localparam int TW = 4;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_tag = '0;
  logic [NR:0]   stage_en;
  logic [BL-1:0] res_data;
  logic          key_valid = 1'b0;
  logic          key_ready;
  logic          key_start;
  logic          key_done = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BL-1:0] out_data;
  logic [TW-1:0] out_tag;
`ifdef AES_PIPE_PERF_EN
  logic [31:0]   perf_blocks;
  logic [31:0]   perf_stalls;
`endif

  logic [BL-1:0] in_data = '0;
  logic [BL-1:0] dsh [0:NR+1];
  logic [TW+BL-1:0] sb [$];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [BL-1:0] data;
    logic [TW-1:0] exp_tag;
    logic [BL-1:0] exp_data;
    int            exp_lat;
  } vec_t;

  vec_t vecs [4];

  aes_pipe_ctrl #(
    .NR           (NR),
    .BLOCK_LENGTH (BL),
    .TAG_W        (TW),
    .OUT_DEPTH    (OD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .stage_en  (stage_en),
    .res_data  (res_data),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_start (key_start),
    .key_done  (key_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef AES_PIPE_PERF_EN
    .perf_blocks (perf_blocks),
    .perf_stalls (perf_stalls),
`endif
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Stand-in round datapath: data accepted at edge e0 appears after edge e(NR+1).
  always @(posedge clk) begin
    dsh[0] <= in_data;
    for (int i = 1; i <= NR + 1; i++) dsh[i] <= dsh[i-1];
  end
  assign res_data = dsh[NR+1];

  task automatic chk(input string name, input logic [TW+BL-1:0] act, input logic [TW+BL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Key handshake, then key_done after dly cycles of EXPAND; ends in RUN.
  task automatic load_key(input int dly);
    int t;
    int starts;
    t = 0;
    starts = 0;
    key_valid = 1'b1;
    while (!key_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk1("key_handshake_seen", key_ready, 1'b1);
    @(negedge clk);
    key_valid = 1'b0;
    for (int c = 0; c < dly + 3; c++) begin
      if (c == 0) chk1("expand_key_ready", key_ready, 1'b0);
      if (key_start) starts++;
      key_done = (c == dly);
      @(negedge clk);
    end
    key_done = 1'b0;
    chk("key_start_cycles", 132'(starts), 132'(1));
    #1 chk1("run_in_ready", in_ready, 1'b1);
    $display("key load: key_done after %0d cycles, key_start pulses=%0d", dly, starts);
  endtask

  // Pop n results in order against the scoreboard; cycles taken returned.
  task automatic drain(input int n, output int cycles);
    int got;
    logic [TW+BL-1:0] e;
    got = 0;
    cycles = 0;
    out_ready = 1'b1;
    while (got < n && cycles < 80) begin
      if (out_valid) begin
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("pop_order", {out_tag, out_data}, e);
        $display("pop tag=%h data=%h", out_tag, out_data);
        got++;
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b0;
    chk("pop_count", 132'(got), 132'(n));
  endtask

  initial begin
    int lat;
    int walk_bad;
    int nacc;
    int cyc;
    int kr_first;
    int ks_first;
    int got;
    int seen;
    logic [NR:0] exp_en;
    logic [TW+BL-1:0] e;

    vecs[0] = '{4'h3, {16{8'hA5}}, 4'h3, {16{8'hA5}}, 13};
    vecs[1] = '{4'hF, {128{1'b1}}, 4'hF, {128{1'b1}}, 13};
    vecs[2] = '{4'h0, 128'h0123456789ABCDEF_FEDCBA9876543210, 4'h0,
                128'h0123456789ABCDEF_FEDCBA9876543210, 13};
    vecs[3] = '{4'hA, 128'h0, 4'hA, 128'h0, 13};

    // Reset values while rst is held low.
    @(negedge clk);
    @(negedge clk);
    chk("rst_stage_en", 132'(stage_en), 132'(0));
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_key_ready", key_ready, 1'b0);
    chk1("rst_key_start", key_start, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", 132'(out_data), 132'(0));
    chk("rst_out_tag", 132'(out_tag), 132'(0));
    rst = 1'b1;
    #1 chk1("idle_key_ready", key_ready, 1'b1);
    chk1("idle_in_ready", in_ready, 1'b0);

    load_key(5);

    // Single blocks: stage walk, latency, tag/data and hold while not ready.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_tag = vecs[i].tag;
      in_data = vecs[i].data;
      out_ready = 1'b0;
      #1 chk1("single_in_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data = '0;
      lat = -1;
      walk_bad = 0;
      for (int k = 1; k <= 30 && lat < 0; k++) begin
        exp_en = (k <= NR + 1) ? ((NR+1)'(1) << (k - 1)) : '0;
        if (stage_en !== exp_en) walk_bad++;
        if (out_valid) lat = k;
        else @(negedge clk);
      end
      chk("single_stage_walk_errs", 132'(walk_bad), 132'(0));
      chk("single_latency", 132'(lat), 132'(vecs[i].exp_lat));
      chk("single_tag", 132'(out_tag), 132'(vecs[i].exp_tag));
      chk("single_data", 132'(out_data), 132'(vecs[i].exp_data));
      @(negedge clk);
      chk1("hold_valid", out_valid, 1'b1);
      chk("hold_head", {out_tag, out_data}, {vecs[i].exp_tag, vecs[i].exp_data});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk1("single_popped", out_valid, 1'b0);
      $display("vector %0d tag=%h latency=%0d", i, vecs[i].tag, lat);
    end

    // Credit limit: continuous offers with no pops admit exactly OUT_DEPTH blocks.
    for (int round = 0; round < 2; round++) begin
      nacc = 0;
      for (int c = 0; c < 30; c++) begin
        in_valid = 1'b1;
        in_tag = TW'(c + round * 4);
        in_data = {8{16'hC000 + 16'(c + round * 4)}};
        #1;
        if (in_ready) begin
          nacc++;
          sb.push_back({in_tag, in_data});
        end
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk("credit_accepts", 132'(nacc), 132'(4));
      chk1("credit_full_in_ready", in_ready, 1'b0);
      chk1("credit_full_out_valid", out_valid, 1'b1);
      $display("credit burst %0d accepted %0d", round, nacc);
      drain(4, cyc);
      chk("credit_pop_cycles", 132'(cyc), 132'(4));
    end

    // Key request in RUN withdrawn during DRAIN returns to RUN without reload.
    in_valid = 1'b1;
    in_tag = 4'h5;
    in_data = {4{32'h5555_0001}};
    #1 chk1("abort_accept", in_ready, 1'b1);
    sb.push_back({in_tag, in_data});
    @(negedge clk);
    in_valid = 1'b0;
    key_valid = 1'b1;
    #1 chk1("abort_keyv_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk1("abort_drain_key_ready", key_ready, 1'b0);
    key_valid = 1'b0;
    @(negedge clk);
    #1 chk1("abort_back_to_run", in_ready, 1'b1);
    chk1("abort_no_key_start", key_start, 1'b0);
    drain(1, cyc);
    $display("drain abort returned to RUN");

    // Reload with 3 in flight: drain first, then EXPAND; key_done in key_start cycle.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_tag = TW'(8 + c);
      in_data = {16{8'h10 + 8'(c)}};
      #1 chk1("reload_accept", in_ready, 1'b1);
      sb.push_back({in_tag, in_data});
      @(negedge clk);
    end
    in_valid = 1'b1;
    key_valid = 1'b1;
    kr_first = -1;
    ks_first = -1;
    got = 0;
    for (int c = 3; c < 40; c++) begin
      if (c == 3) begin
        #1 chk1("reload_in_ready_drop", in_ready, 1'b0);
        in_valid = 1'b0;
      end
      if (key_ready && kr_first < 0) kr_first = c;
      if (out_valid) begin
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("reload_pop_order", {out_tag, out_data}, e);
        got++;
      end
      if (key_start) begin
        ks_first = c;
        key_valid = 1'b0;
        key_done = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    key_done = 1'b0;
    out_ready = 1'b0;
    chk("reload_key_ready_cycle", 132'(kr_first), 132'(15));
    chk("reload_key_start_cycle", 132'(ks_first), 132'(16));
    chk("reload_results", 132'(got), 132'(3));
    #1 chk1("reload_run_in_ready", in_ready, 1'b1);
    $display("reload: key_ready at %0d, key_start at %0d, results %0d", kr_first, ks_first, got);

    // Reset mid-stream discards in-flight blocks.
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_tag = TW'(c);
      in_data = {4{32'hDEAD_0000 + 32'(c)}};
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_stage_en", 132'(stage_en), 132'(0));
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_idle_key_ready", key_ready, 1'b1);
    chk1("midrst_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("midrst_stale_results", 132'(seen), 132'(0));
    $display("mid-stream reset: stale results seen=%0d", seen);

`ifdef AES_PIPE_PERF_EN
    // Perf counters: 7 stalled offers in IDLE, then 10 popped blocks.
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    load_key(1);
    for (int b = 0; b < 10; b++) begin
      in_valid = 1'b1;
      in_tag = TW'(b);
      in_data = {4{32'hBEEF_0000 + 32'(b)}};
      #1 chk1("perf_accept", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int t = 0; t < 30 && !out_valid; t++) @(negedge clk);
      chk1("perf_result", out_valid, 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("perf_blocks", 132'(perf_blocks), 132'(10));
    chk("perf_stalls", 132'(perf_stalls), 132'(7));
    $display("perf: blocks=%0d stalls=%0d", perf_blocks, perf_stalls);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
